click_sequencer: RTL and testbench
==================================

Name: click_sequencer

Overview:
- Sits between line_decoder and a multi-cycle dial_tracker variant that accepts one rotation command at a time and reports its zero-crossing count some cycles later.
- Buffers decoded click commands in a small FIFO and issues them one at a time over a req/ready handshake.
- Accumulates the returned crossing counts into the puzzle result.
- Asserts result_valid once end-of-file has been seen and every buffered command has completed; this feeds tap_encoder.

Parameters:
CLICK_BITS, 10, width of click count and crossing count.
RESULT_WIDTH, 16, accumulator/result width.
FIFO_DEPTH, 4, command FIFO entries; power of two, >= 2.

Ports:
tck  input  1  JTAG clock; sole clock, all state on rising edge.
test_logic_reset_n  input  1  asynchronous active-low reset.
click_valid  input  1  one-cycle strobe, decoded command present.
click_right_left  input  1  direction of command.
click_count  input  CLICK_BITS  click magnitude.
end_of_file  input  1  held high once the last line is decoded.
tracker_req  output  1  command offered to tracker.
tracker_ready  input  1  tracker accepts when tracker_req & tracker_ready.
tracker_right_left  output  1  direction of issued command.
tracker_count  output  CLICK_BITS  magnitude of issued command.
tracker_done  input  1  one-cycle strobe, issued command finished.
tracker_crossings  input  CLICK_BITS  crossings for finished command, valid with tracker_done.
result_valid  output  1  final result available; held until reset.
result_data  output  RESULT_WIDTH  running or final crossing total.
fifo_overflow  output  1  sticky: a command was dropped.
result_saturated  output  1  sticky: accumulator clamped.

Behaviour:
- Reset (async, while low): all outputs 0; FIFO empty; eof latch 0; state IDLE. Asserting reset mid-handshake drops tracker_req immediately; any outstanding tracker response is lost.
- FIFO push: on click_valid when not full, or when full and a pop occurs on the same edge. Push while full without a pop is dropped and sets fifo_overflow.
- Clicks with end_of_file already latched are ignored and not flagged. A click in the same cycle end_of_file first rises is accepted.
- eof latch: set on the first edge with end_of_file = 1.
- FSM states:
  - IDLE: if FIFO is non-empty, pop the head, register tracker_right_left/tracker_count, set tracker_req = 1, go to ISSUE. Else if eof is latched, go to DONE.
  - ISSUE: tracker_req = 1 and the command outputs are held stable until the edge where tracker_ready = 1; then tracker_req = 0 and go to WAIT.
  - WAIT: on tracker_done, result_data <= result_data + zero-extended tracker_crossings; go to IDLE.
  - DONE: result_valid = 1; terminal until reset.
- Latency: click_valid sampled at edge k into an empty FIFO with FSM in IDLE makes tracker_req visible after edge k+1. tracker_done at edge m makes the updated result_data visible after edge m. The next tracker_req is visible after edge m+1.
- Exactly one command outstanding at a time. tracker_done outside WAIT is ignored.
- A tracker_done in the same cycle as the tracker_ready acceptance is not allowed by tracker protocol; the bench must not generate it.
- Zero-magnitude commands are issued normally.
- Saturation: if the sum exceeds 2^RESULT_WIDTH-1, result_data clamps to all ones and result_saturated is set.
- result_data is live during operation; consumers qualify it with result_valid.
- end_of_file with an empty FIFO and FSM in IDLE gives result_valid after two edges: latch, then the IDLE->DONE transition.

Test Plan:
- Single command:
  - Stimulus: R50 click, tracker_ready tied 1, done 3 cycles later with crossings = 1, then end_of_file.
  - Required: tracker_count = 50 with right_left = 1; result_data = 1; result_valid = 1.
- Back-pressure:
  - Stimulus: tracker_ready held 0 for 10 cycles during ISSUE.
  - Required: tracker_req stays 1; count and direction stable; acceptance on the first ready cycle.
- Ordering:
  - Stimulus: burst of 4 clicks on consecutive cycles (L68, L30, R48, L5); tracker done delay 5 cycles.
  - Required: issued in order, no drops, fifo_overflow = 0.
- Overflow:
  - Stimulus: FIFO_DEPTH = 4, tracker_ready = 0, 6 clicks.
  - Required: fifo_overflow = 1; exactly 5 commands issued (1 held in ISSUE plus 4 buffered) once ready rises.
- Saturation and early EOF:
  - Stimulus: RESULT_WIDTH = 4; crossings 9 then 9; end_of_file asserted while the second command is in WAIT.
  - Required: result_valid stays 0 until the second tracker_done; result_data = 15; result_saturated = 1.
- Reset mid-operation:
  - Stimulus: drop test_logic_reset_n while in ISSUE.
  - Required: all outputs 0 immediately; a fresh sequence after release behaves as from power-up.

Source files
------------

// File: rtl/click_sequencer.sv
// click_sequencer: buffers decoded click commands, issues them one at a
// time to a multi-cycle dial tracker, and accumulates returned crossings.
//
// Ports:
//   tck, test_logic_reset_n         clock / async active-low reset
//   click_valid, click_right_left,
//   click_count, end_of_file        decoded command stream from line_decoder
//   tracker_req, tracker_ready,
//   tracker_right_left,
//   tracker_count                   command issue handshake
//   tracker_done, tracker_crossings completion report from tracker
//   result_valid, result_data       crossing total, final once valid
//   fifo_overflow                   sticky: a command was dropped
//   result_saturated                sticky: accumulator clamped
module click_sequencer #(
    parameter int CLICK_BITS   = 10,
    parameter int RESULT_WIDTH = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    tck,
    input  logic                    test_logic_reset_n,
    input  logic                    click_valid,
    input  logic                    click_right_left,
    input  logic [CLICK_BITS-1:0]   click_count,
    input  logic                    end_of_file,
    output logic                    tracker_req,
    input  logic                    tracker_ready,
    output logic                    tracker_right_left,
    output logic [CLICK_BITS-1:0]   tracker_count,
    input  logic                    tracker_done,
    input  logic [CLICK_BITS-1:0]   tracker_crossings,
    output logic                    result_valid,
    output logic [RESULT_WIDTH-1:0] result_data,
    output logic                    fifo_overflow,
    output logic                    result_saturated
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int SUM_W = ((RESULT_WIDTH > CLICK_BITS) ?
                            RESULT_WIDTH : CLICK_BITS) + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    // Entry layout: {direction, magnitude}
    logic [CLICK_BITS:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0]         wr_ptr;
    logic [AW:0]         rd_ptr;
    logic                fifo_empty;
    logic                fifo_full;
    logic [CLICK_BITS:0] fifo_head;

    logic eof_q;
    logic click_ok;
    logic push;
    logic drop;
    logic pop;
    logic accum;

    logic [SUM_W-1:0] sum;
    logic             sum_sat;

    // Extra pointer bit separates full from empty
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_head  = fifo_mem[rd_ptr[AW-1:0]];

    // Clicks after the eof latch are silently ignored
    assign click_ok = click_valid && !eof_q;
    // A full FIFO still accepts when the head leaves on the same edge
    assign push     = click_ok && (!fifo_full || pop);
    assign drop     = click_ok && fifo_full && !pop;

    assign sum     = SUM_W'(result_data) + SUM_W'(tracker_crossings);
    assign sum_sat = |sum[SUM_W-1:RESULT_WIDTH];

    always_ff @(posedge tck or negedge test_logic_reset_n) begin
        if (!test_logic_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = ISSUE;
                end else if (eof_q) begin
                    state_d = DONE;
                end
            end
            ISSUE: begin
                if (tracker_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (tracker_done) begin
                    state_d = IDLE;
                end
            end
            DONE: state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tracker_req  = (state_q == ISSUE);
        result_valid = (state_q == DONE);
        pop          = (state_q == IDLE) && !fifo_empty;
        accum        = (state_q == WAIT) && tracker_done;
    end

    always_ff @(posedge tck) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= {click_right_left, click_count};
        end
    end

    always_ff @(posedge tck or negedge test_logic_reset_n) begin
        if (!test_logic_reset_n) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            eof_q              <= 1'b0;
            fifo_overflow      <= 1'b0;
            tracker_right_left <= 1'b0;
            tracker_count      <= '0;
            result_data        <= '0;
            result_saturated   <= 1'b0;
        end else begin
            if (end_of_file) begin
                eof_q <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (drop) begin
                fifo_overflow <= 1'b1;
            end
            if (pop) begin
                rd_ptr             <= rd_ptr + 1'b1;
                tracker_right_left <= fifo_head[CLICK_BITS];
                tracker_count      <= fifo_head[CLICK_BITS-1:0];
            end
            if (accum) begin
                if (sum_sat) begin
                    result_data      <= '1;
                    result_saturated <= 1'b1;
                end else begin
                    result_data <= sum[RESULT_WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_click_sequencer.sv
// tb_click_sequencer: directed scenarios for click_sequencer, built with
// a 4-bit accumulator so saturation is reachable with small counts.
module tb_click_sequencer;

    localparam int CB = 10;
    localparam int RW = 4;

    logic          tck = 1'b0;
    logic          test_logic_reset_n = 1'b0;
    logic          click_valid = 1'b0;
    logic          click_right_left = 1'b0;
    logic [CB-1:0] click_count = '0;
    logic          end_of_file = 1'b0;
    logic          tracker_req;
    logic          tracker_ready = 1'b0;
    logic          tracker_right_left;
    logic [CB-1:0] tracker_count;
    logic          tracker_done = 1'b0;
    logic [CB-1:0] tracker_crossings = '0;
    logic          result_valid;
    logic [RW-1:0] result_data;
    logic          fifo_overflow;
    logic          result_saturated;

    int checks = 0;
    int failures = 0;

    logic [CB-1:0] ord_cnt [4] = '{10'd68, 10'd30, 10'd48, 10'd5};
    logic          ord_rl  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    click_sequencer #(
        .CLICK_BITS  (CB),
        .RESULT_WIDTH(RW),
        .FIFO_DEPTH  (4)
    ) dut (
        .tck               (tck),
        .test_logic_reset_n(test_logic_reset_n),
        .click_valid       (click_valid),
        .click_right_left  (click_right_left),
        .click_count       (click_count),
        .end_of_file       (end_of_file),
        .tracker_req       (tracker_req),
        .tracker_ready     (tracker_ready),
        .tracker_right_left(tracker_right_left),
        .tracker_count     (tracker_count),
        .tracker_done      (tracker_done),
        .tracker_crossings (tracker_crossings),
        .result_valid      (result_valid),
        .result_data       (result_data),
        .fifo_overflow     (fifo_overflow),
        .result_saturated  (result_saturated)
    );

    always #5 tck = ~tck;

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic do_reset();
        test_logic_reset_n = 1'b0;
        click_valid = 1'b0;
        click_right_left = 1'b0;
        click_count = '0;
        end_of_file = 1'b0;
        tracker_ready = 1'b0;
        tracker_done = 1'b0;
        tracker_crossings = '0;
        tick();
        tick();
        test_logic_reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [23:0] got;
        test_logic_reset_n = 1'b0;
        tick();
        got = {tracker_req, tracker_right_left, tracker_count,
               result_valid, result_data, fifo_overflow,
               result_saturated, 4'd0};
        checks++;
        if (got !== 24'd0) begin
            failures++;
            $display("FAIL reset_outs got=%h exp=0", got);
        end
        test_logic_reset_n = 1'b1;
        tick();
        tick();
        checks++;
        if (tracker_req !== 1'b0 || result_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle req=%b valid=%b exp=0/0",
                     tracker_req, result_valid);
        end
    endtask

    task automatic test_single();
        do_reset();
        tracker_ready = 1'b1;
        click_valid = 1'b1;
        click_right_left = 1'b1;
        click_count = 10'd50;
        tick();
        click_valid = 1'b0;
        checks++;
        if (tracker_req !== 1'b0) begin
            failures++;
            $display("FAIL single_early_req got=%b exp=0", tracker_req);
        end
        tick();
        checks++;
        if (tracker_req !== 1'b1 || tracker_count !== 10'd50 ||
            tracker_right_left !== 1'b1) begin
            failures++;
            $display("FAIL single_issue req=%b cnt=%0d rl=%b exp=1/50/1",
                     tracker_req, tracker_count, tracker_right_left);
        end
        tick();
        checks++;
        if (tracker_req !== 1'b0) begin
            failures++;
            $display("FAIL single_accept req=%b exp=0", tracker_req);
        end
        tick();
        tick();
        tracker_done = 1'b1;
        tracker_crossings = 10'd1;
        tick();
        tracker_done = 1'b0;
        checks++;
        if (result_data !== 4'd1) begin
            failures++;
            $display("FAIL single_result got=%0d exp=1", result_data);
        end
        end_of_file = 1'b1;
        tick();
        checks++;
        if (result_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_valid_early got=%b exp=0", result_valid);
        end
        tick();
        checks++;
        if (result_valid !== 1'b1 || result_data !== 4'd1) begin
            failures++;
            $display("FAIL single_valid got=%b/%0d exp=1/1",
                     result_valid, result_data);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        do_reset();
        click_valid = 1'b1;
        click_right_left = 1'b0;
        click_count = 10'd7;
        tick();
        click_valid = 1'b0;
        tick();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (tracker_req !== 1'b1 || tracker_count !== 10'd7 ||
                tracker_right_left !== 1'b0) begin
                failures++;
                bad++;
                $display("FAIL bp_hold cyc=%0d req=%b cnt=%0d rl=%b exp=1/7/0",
                         i, tracker_req, tracker_count, tracker_right_left);
            end
            tick();
        end
        tracker_ready = 1'b1;
        tick();
        tracker_ready = 1'b0;
        checks++;
        if (tracker_req !== 1'b0) begin
            failures++;
            $display("FAIL bp_accept req=%b exp=0", tracker_req);
        end
        tick();
        tracker_done = 1'b1;
        tracker_crossings = 10'd2;
        tick();
        tracker_done = 1'b0;
        checks++;
        if (result_data !== 4'd2) begin
            failures++;
            $display("FAIL bp_result got=%0d exp=2", result_data);
        end
    endtask

    task automatic test_ordering();
        int n;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            click_valid = 1'b1;
            click_right_left = ord_rl[i];
            click_count = ord_cnt[i];
            tick();
        end
        click_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (tracker_req !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            checks++;
            if (tracker_req !== 1'b1 || tracker_count !== ord_cnt[i] ||
                tracker_right_left !== ord_rl[i]) begin
                failures++;
                $display("FAIL ord_cmd%0d req=%b cnt=%0d rl=%b exp=1/%0d/%b",
                         i, tracker_req, tracker_count, tracker_right_left,
                         ord_cnt[i], ord_rl[i]);
            end
            tracker_ready = 1'b1;
            tick();
            tracker_ready = 1'b0;
            for (int d = 0; d < 4; d++) tick();
            tracker_done = 1'b1;
            tracker_crossings = CB'(i + 1);
            tick();
            tracker_done = 1'b0;
        end
        checks++;
        if (result_data !== 4'd10 || fifo_overflow !== 1'b0) begin
            failures++;
            $display("FAIL ord_total got=%0d ovf=%b exp=10/0",
                     result_data, fifo_overflow);
        end
    endtask

    task automatic test_overflow();
        int n;
        int extra;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            click_valid = 1'b1;
            click_right_left = i[0];
            click_count = CB'(i + 1);
            tick();
        end
        click_valid = 1'b0;
        checks++;
        if (fifo_overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_flag got=%b exp=1", fifo_overflow);
        end
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (tracker_req !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            checks++;
            if (tracker_req !== 1'b1 || tracker_count !== CB'(i + 1) ||
                tracker_right_left !== i[0]) begin
                failures++;
                $display("FAIL ovf_cmd%0d req=%b cnt=%0d rl=%b exp=1/%0d/%b",
                         i, tracker_req, tracker_count, tracker_right_left,
                         i + 1, i[0]);
            end
            tracker_ready = 1'b1;
            tick();
            tracker_ready = 1'b0;
            tick();
            tracker_done = 1'b1;
            tracker_crossings = 10'd1;
            tick();
            tracker_done = 1'b0;
        end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            if (tracker_req === 1'b1) extra++;
            tick();
        end
        checks++;
        if (extra != 0 || result_data !== 4'd5) begin
            failures++;
            $display("FAIL ovf_count extra=%0d total=%0d exp=0/5",
                     extra, result_data);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        tracker_ready = 1'b1;
        click_valid = 1'b1;
        click_right_left = 1'b1;
        click_count = 10'd3;
        tick();
        click_valid = 1'b0;
        tick();
        tick();
        tracker_done = 1'b1;
        tracker_crossings = 10'd9;
        tick();
        tracker_done = 1'b0;
        checks++;
        if (result_data !== 4'd9 || result_saturated !== 1'b0) begin
            failures++;
            $display("FAIL sat_first got=%0d sat=%b exp=9/0",
                     result_data, result_saturated);
        end
        click_valid = 1'b1;
        click_count = 10'd4;
        tick();
        click_valid = 1'b0;
        tick();
        tick();
        end_of_file = 1'b1;
        tick();
        tick();
        checks++;
        if (result_valid !== 1'b0) begin
            failures++;
            $display("FAIL sat_early_valid got=%b exp=0", result_valid);
        end
        tracker_done = 1'b1;
        tracker_crossings = 10'd9;
        tick();
        tracker_done = 1'b0;
        checks++;
        if (result_data !== 4'd15 || result_saturated !== 1'b1 ||
            result_valid !== 1'b0) begin
            failures++;
            $display("FAIL sat_clamp got=%0d sat=%b valid=%b exp=15/1/0",
                     result_data, result_saturated, result_valid);
        end
        tick();
        checks++;
        if (result_valid !== 1'b1) begin
            failures++;
            $display("FAIL sat_valid got=%b exp=1", result_valid);
        end
        click_valid = 1'b1;
        tick();
        click_valid = 1'b0;
        tick();
        checks++;
        if (tracker_req !== 1'b0 || fifo_overflow !== 1'b0 ||
            result_valid !== 1'b1) begin
            failures++;
            $display("FAIL sat_post_eof req=%b ovf=%b valid=%b exp=0/0/1",
                     tracker_req, fifo_overflow, result_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] got;
        do_reset();
        tracker_ready = 1'b1;
        click_valid = 1'b1;
        click_right_left = 1'b1;
        click_count = 10'd12;
        tick();
        click_right_left = 1'b0;
        click_count = 10'd20;
        tick();
        click_valid = 1'b0;
        tick();
        tracker_ready = 1'b0;
        tracker_done = 1'b1;
        tracker_crossings = 10'd5;
        tick();
        tracker_done = 1'b0;
        click_valid = 1'b1;
        click_right_left = 1'b1;
        click_count = 10'd33;
        tick();
        click_valid = 1'b0;
        tick();
        checks++;
        if (tracker_req !== 1'b1 || result_data !== 4'd5 ||
            tracker_count !== 10'd20) begin
            failures++;
            $display("FAIL mid_setup req=%b total=%0d cnt=%0d exp=1/5/20",
                     tracker_req, result_data, tracker_count);
        end
        #2;
        test_logic_reset_n = 1'b0;
        #1;
        got = {tracker_req, tracker_right_left, tracker_count,
               result_valid, result_data, fifo_overflow,
               result_saturated, 4'd0};
        checks++;
        if (got !== 24'd0) begin
            failures++;
            $display("FAIL mid_reset got=%h exp=0", got);
        end
        tick();
        test_logic_reset_n = 1'b1;
        tick();
        tracker_ready = 1'b1;
        click_valid = 1'b1;
        click_right_left = 1'b1;
        click_count = 10'd9;
        tick();
        click_valid = 1'b0;
        tick();
        checks++;
        if (tracker_req !== 1'b1 || tracker_count !== 10'd9 ||
            tracker_right_left !== 1'b1) begin
            failures++;
            $display("FAIL mid_fresh req=%b cnt=%0d rl=%b exp=1/9/1",
                     tracker_req, tracker_count, tracker_right_left);
        end
        tick();
        tracker_done = 1'b1;
        tracker_crossings = 10'd2;
        tick();
        tracker_done = 1'b0;
        tick();
        checks++;
        if (result_data !== 4'd2 || tracker_req !== 1'b0) begin
            failures++;
            $display("FAIL mid_fresh_total got=%0d req=%b exp=2/0",
                     result_data, tracker_req);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_ordering();
        test_overflow();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
